div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage; the responder side of the hazard unit's divide handshake.
- Accepts div_start, which hazard logic holds high and uses to stall F/D/E while a DIV/DIVU is in EX.
- Computes the quotient and remainder for signed or unsigned operands.
- Pulses ready for one cycle with the result, which the HI/LO write path consumes.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1  input  WIDTH  dividend; sampled with start.
- opdata2  input  WIDTH  divisor; sampled with start.
- start  input  1  request level, driven by hazard div_start.
- annul  input  1  cancel the in-flight division (pipeline flush).
- result  output  2*WIDTH  {remainder, quotient}: upper half goes to HI, lower half to LO.
- ready  output  1  1 = `DivResultReady, 0 = `DivResultNotReady.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=0, result=0, internal registers cleared.
  - Reset mid-operation aborts immediately.
- IDLE:
  - If start=1 and annul=0: latch operands and signed_div.
  - If signed_div=1, convert negative operands to magnitude (two's-complement negate) and record sign_q = op1[MSB]^op2[MSB] and sign_r = op1[MSB].
  - If the divisor is 0, go to ZERO; otherwise go to BUSY with cnt=0 and partial remainder = 0.
- BUSY:
  - Each cycle performs one restoring iteration: shift {rem, dividend} left by 1; if rem >= divisor, subtract and set the quotient bit.
  - cnt increments; after WIDTH iterations (cnt == WIDTH-1 on the last one) go to DONE.
  - Operand input changes during BUSY are ignored.
- ZERO: one cycle, then DONE with quotient=0 and remainder=0.
- DONE:
  - ready=1 for exactly one cycle; result = {rem_final, quot_final}.
  - Signed mode: quotient is negated if sign_q, remainder is negated if sign_r.
  - Next state is always IDLE, regardless of start.
  - A start=1 seen in the following IDLE cycle begins a new division (back-to-back DIVs).
- Latency:
  - Counting the IDLE cycle with start=1 as cycle 0, ready=1 in cycle WIDTH+1 (33).
  - Divide-by-zero: ready=1 in cycle 2.
- result:
  - Registered; updated only on entry to DONE.
  - Holds its last value while ready=0 (after reset: 0).
- annul=1 in any state:
  - Next state IDLE, ready=0, result unchanged, no pulse is produced.
  - annul takes priority over start in the same cycle.
- start dropping while BUSY without annul: the division completes and pulses ready anyway; hazard logic must use annul to cancel.
- Arithmetic:
  - Magnitudes use WIDTH bits plus a WIDTH+1-bit compare/subtract.
  - -2^(WIDTH-1) / -1 wraps: quotient 0x80000000, remainder 0, no trap.
- Single outstanding operation; no queueing.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined: in IDLE with a non-zero divisor and magnitude(dividend) < magnitude(divisor) (unsigned compare after abs), go directly to DONE with quotient 0 and remainder = magnitude(dividend), then apply the sign fix-up. ready=1 in cycle 1.
- Undefined: this case takes the full 33-cycle BUSY path and gives identical result values.

Test Plan:
- Unsigned 100/7: start=1 held until ready -> ready=1 only in cycle 33, result = {32'd2, 32'd14}; ready=0 in cycle 34.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7/-2 -> {32'h00000001, 32'hFFFFFFFD}.
- Divisor 0 (any dividend) -> ready=1 in cycle 2, result = 64'h0; signed 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}.
- annul=1 in BUSY cycle 10 -> ready stays 0 for 40 cycles, result unchanged; a new start 2 cycles later gives a correct result in 33 cycles.
- rst=0 asserted asynchronously mid-BUSY (between edges) -> ready=0 and result=0 immediately; after release, IDLE accepts start.
- With DIV_FASTPATH_EN: unsigned 3/10 -> ready=1 in cycle 1, result = {32'd3, 32'd0}. Without it: same result in cycle 33.

Source files
------------

// File: rtl/div_unit_if.sv
// Divide handshake bundle between the hazard/EX side and the divider.
// master drives the request; slave answers with result/ready.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, result = {remainder, quotient}.
// Optional early-out for |dividend| < |divisor| under DIV_FASTPATH_EN.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dsr;
    logic [CW-1:0]      cnt;
    logic               sign_q;
    logic               sign_r;
    logic [2*WIDTH-1:0] res;

    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             fast;
    logic [WIDTH:0]   shf;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fr_fix;

    assign neg1 = bus.signed_div & bus.opdata1[WIDTH-1];
    assign neg2 = bus.signed_div & bus.opdata2[WIDTH-1];
    assign mag1 = neg1 ? -bus.opdata1 : bus.opdata1;
    assign mag2 = neg2 ? -bus.opdata2 : bus.opdata2;

`ifdef DIV_FASTPATH_EN
    assign fast = (mag1 < mag2);
`else
    assign fast = 1'b0;
`endif

    // One restoring step: the borrow bit of the WIDTH+1 subtract decides.
    assign shf   = {rem, quo[WIDTH-1]};
    assign diff  = shf - {1'b0, dsr};
    assign qbit  = ~diff[WIDTH];
    assign rem_n = qbit ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], qbit};

    assign q_fix  = sign_q ? -quo_n : quo_n;
    assign r_fix  = sign_r ? -rem_n : rem_n;
    assign fr_fix = neg1 ? -mag1 : mag1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state; annul overrides everything, including start.
    always_comb begin
        state_n = state;
        if (bus.annul) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.opdata2 == '0) state_n = ZERO;
                        else if (fast)         state_n = DONE;
                        else                   state_n = BUSY;
                    end
                end
                BUSY:    if (cnt == LAST) state_n = DONE;
                ZERO:    state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs: one-cycle ready pulse in DONE, registered result.
    always_comb begin
        bus.ready  = (state == DONE);
        bus.result = res;
    end

    // Operand capture, iteration datapath and result capture on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem    <= '0;
            quo    <= '0;
            dsr    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            res    <= '0;
        end else begin
            if (state == IDLE && bus.start && !bus.annul) begin
                rem    <= '0;
                quo    <= mag1;
                dsr    <= mag2;
                cnt    <= '0;
                sign_q <= neg1 ^ neg2;
                sign_r <= neg1;
            end else if (state == BUSY) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 1'b1;
            end
            if (state_n == DONE) begin
                if (state == BUSY)      res <= {r_fix, q_fix};
                else if (state == ZERO) res <= '0;
                else                    res <= {fr_fix, {WIDTH{1'b0}}};
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus scoreboard queue,
// with hand-written annul and asynchronous-reset sequences.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } sb_t;

    sb_t         sb_q[$];
    vec_t        vt[11];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [63:0] last_res = '0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic int lat_of(input logic sg, input logic [31:0] a,
                                  input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        if (b == 0) return 2;
`ifdef DIV_FASTPATH_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [63:0] model(input logic sg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 0) return 64'h0;
        if (sg) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        sb_t e;
        int  k;
        bit  got;
        sb_q.push_back('{res: exp, lat: lat_of(sg, a, b)});
        @(negedge clk);
        bus.signed_div = sg;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.ready) got = 1'b1;
        end
        bus.start = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout %h/%h: no ready in 40 cycles, expected cycle %0d",
                     a, b, e.lat);
        end else begin
            check("latency", 64'(k), 64'(e.lat));
            check("result", bus.result, e.res);
            last_res = e.res;
            @(posedge clk);
            #1;
            check("ready_drop", 64'(bus.ready), 64'h0);
        end
    endtask

    initial begin
        bit seen;

        vt[0]  = '{1'b0, 32'd100,       32'd7,         {32'd2, 32'd14}};
        vt[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002,  {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vt[2]  = '{1'b1, 32'h00000007,  32'hFFFFFFFE,  {32'h00000001, 32'hFFFFFFFD}};
        vt[3]  = '{1'b0, 32'd12345,     32'd0,         64'h0};
        vt[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000}};
        vt[5]  = '{1'b0, 32'd3,         32'd10,        {32'd3, 32'd0}};
        vt[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         {32'h0, 32'hFFFFFFFF}};
        vt[7]  = '{1'b1, 32'h80000000,  32'd0,         64'h0};
        vt[8]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  {32'h0, 32'h1}};
        vt[9]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFF9,  {32'h0, 32'h1}};
        vt[10] = '{1'b1, 32'hFFFFFFFD,  32'd10,        {32'hFFFFFFFD, 32'h0}};

        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;

        #12;
        check("reset_ready", 64'(bus.ready), 64'h0);
        check("reset_result", bus.result, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vt[i]) run_div(vt[i].sg, vt[i].a, vt[i].b, vt[i].exp);

        for (int i = 0; i < 4; i++) begin
            logic        sg;
            logic [31:0] a;
            logic [31:0] b;
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            run_div(sg, a, b, model(sg, a, b));
        end

        // annul during BUSY cycle 10: no pulse, result held.
        @(negedge clk);
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        bus.start      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.annul = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) seen = 1'b1;
        end
        check("annul_no_ready", 64'(seen), 64'h0);
        check("annul_result_held", bus.result, last_res);
        repeat (2) @(negedge clk);
        run_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

        // asynchronous reset between edges mid-BUSY.
        @(negedge clk);
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd5;
        bus.start   = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_ready", 64'(bus.ready), 64'h0);
        check("async_rst_result", bus.result, 64'h0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
